// File: rtl/tff_pkg.sv
// Shared definitions for the toggle flip-flop decode path.
//   tff_dec_state_t : output holding register state (EMPTY / FULL)
//   TFF_DEC_*       : default word and toggle-counter widths
package tff_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } tff_dec_state_t;

  localparam int TFF_DEC_W_DEFAULT  = 8;
  localparam int TFF_DEC_CW_DEFAULT = 16;

endpackage

// File: rtl/tff_bit_decode.sv
// Recovers the T input of a toggle flip-flop from its sampled Q line.
//   clk, rst : clock, synchronous active-high reset
//   q_in     : sampled Q line
//   q_valid  : q_in is meaningful this cycle
//   t        : recovered toggle bit (q_in ^ previous q)
//   t_stb    : t is meaningful this cycle
module tff_bit_decode (
  input  logic clk,
  input  logic rst,
  input  logic q_in,
  input  logic q_valid,
  output logic t,
  output logic t_stb
);

  // Reset to 0 to match the flip-flop's power-up state, so the very first
  // sample decodes correctly.
  logic q_ref;

  always_ff @(posedge clk) begin
    if (rst)          q_ref <= 1'b0;
    else if (q_valid) q_ref <= q_in;
  end

  assign t     = q_in ^ q_ref;
  assign t_stb = q_valid;

endmodule

// File: rtl/tff_decoder.sv
// Toggle-encoded serial line to word stream.
// Recovered bits are packed LSB-first into W-bit words and offered on a
// valid/ready port through a single holding register.
//   clk, rst     : clock, synchronous active-high reset
//   q_in/q_valid : sampled TFF output line and its qualifier
//   data_out     : recovered word (LSB = first bit)
//   data_valid   : data_out holds an unconsumed word
//   data_ready   : consumer accepts when data_valid && data_ready
//   overflow     : sticky, a completed word was dropped
//   toggle_count : recovered 1-bits since reset, saturating
module tff_decoder
  import tff_pkg::*;
#(
  parameter int W  = TFF_DEC_W_DEFAULT,
  parameter int CW = TFF_DEC_CW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          q_in,
  input  logic          q_valid,
  output logic [W-1:0]  data_out,
  output logic          data_valid,
  input  logic          data_ready,
  output logic          overflow,
  output logic [CW-1:0] toggle_count
);

  localparam int BCW = (W > 1) ? $clog2(W) : 1;

  logic           t, t_stb;
  logic [BCW-1:0] bit_cnt;
  logic [W-1:0]   sreg;
  logic [W-1:0]   word;
  logic           complete;
  tff_dec_state_t state;

  tff_bit_decode u_bit (
    .clk     (clk),
    .rst     (rst),
    .q_in    (q_in),
    .q_valid (q_valid),
    .t       (t),
    .t_stb   (t_stb)
  );

  assign complete = t_stb && (bit_cnt == BCW'(W - 1));

  // Assembled word including the bit arriving this cycle. Every position is
  // rewritten once per word, so stale bits in sreg never leak through.
  always_comb begin
    word          = sreg;
    word[bit_cnt] = t;
  end

  // Deserializer
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (t_stb) begin
      sreg    <= word;
      bit_cnt <= complete ? '0 : bit_cnt + 1'b1;
    end
  end

  // Holding register FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (complete) begin
            data_out   <= word;
            data_valid <= 1'b1;
            state      <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            // Old word leaves and new one lands in the same cycle when the
            // consumer is ready; otherwise the new word is the one dropped.
            if (data_ready) data_out <= word;
            else            overflow <= 1'b1;
          end else if (data_ready) begin
            data_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        default: begin
          state      <= EMPTY;
          data_valid <= 1'b0;
        end
      endcase
    end
  end

  // Saturating toggle counter
  always_ff @(posedge clk) begin
    if (rst)                                 toggle_count <= '0;
    else if (t_stb && t && ~&toggle_count)   toggle_count <= toggle_count + 1'b1;
  end

endmodule

// File: doc/tff_decoder.md
# tff_decoder

Receive-side counterpart of the toggle flip-flop path. It samples the `q` stream produced by a T flip-flop driven one bit per clock. It recovers each `t` bit as the XOR of the current and previous `q`, deserializes the recovered bits LSB-first into W-bit words, and presents each word on a valid/ready output port. It sits between a toggle-encoded serial line and the word-level consumer, and also reports toggle statistics and overflow.

## Interface
- `W`, default 8: recovered word width, legal range 2..32.
- `CW`, default 16: width of the saturating toggle counter.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `q_in`  in  1  sampled TFF output line.
- `q_valid`  in  1  `q_in` is meaningful this cycle; one recovered bit per valid cycle.
- `data_out`  out  W  recovered word, LSB = first recovered bit.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `data_ready`  in  1  consumer accepts the word when `data_valid && data_ready`.
- `overflow`  out  1  sticky; a completed word was dropped.
- `toggle_count`  out  CW  number of recovered 1-bits since reset, saturating.

## Operation
- Reference register `q_ref` resets to 0, matching TFF power-up `q=0`.
- On each `q_valid` cycle:
  - recovered bit `t = q_in ^ q_ref`;
  - `q_ref <= q_in`;
  - `t` enters shift register position `bit_cnt`;
  - `bit_cnt` increments.
- Cycles with `q_valid=0` change nothing in the decode path.
- State machine with two states, for the output holding register:
  - EMPTY: `data_valid=0`.
  - FULL: `data_valid=1`.
- Word completion: the valid cycle with `bit_cnt == W-1`. That cycle `bit_cnt` wraps to 0, and the assembled word (including the current bit) is offered to the holding register.
  - In EMPTY: load the word, go to FULL.
  - In FULL with `data_ready=1` the same cycle: the old word is consumed and the new word is loaded. Stay FULL, no overflow.
  - In FULL with `data_ready=0`: drop the new word, set `overflow`, stay FULL. The old word is preserved.
- In FULL with `data_ready=1` and no completion: go to EMPTY.
- `toggle_count` increments on every valid cycle where `t=1`. It holds at 2^CW-1 and does not wrap.
- `overflow` clears only on `rst`.

## Timing
- Reset values:
  - `data_out=0`, `data_valid=0`, `overflow=0`, `toggle_count=0`;
  - internally, `q_ref=0`, `bit_cnt=0`, shift register 0, state EMPTY.
- `rst` asserted mid-word discards the partial word and any held word. `rst` has priority over all other inputs in the same cycle.
- Latency: completion on valid cycle n gives `data_valid=1` and the word on `data_out` from cycle n+1.
- `data_out` is stable while `data_valid=1` and not yet consumed.
- `toggle_count` reflects bit n at cycle n+1.
- Throughput: one word per W valid cycles, with no bubbles when `data_ready` is held high.

## Structure
- Shared package `tff_pkg`:
  - state enum `tff_dec_state_t` {EMPTY, FULL};
  - constants `TFF_DEC_W_DEFAULT=8` and `TFF_DEC_CW_DEFAULT=16`.
- One sub-module, `tff_bit_decode`: holds `q_ref`, computes `t`, and emits `t` with a strobe.
- The top level owns `bit_cnt`, the shift register, the holding register, the FSM, the counter and the overflow flag.

## Test plan
- **Basic decode:** W=4. After reset, drive `q_in` = 0,1,1,0 with `q_valid=1` and `data_ready=1`. Expect `data_valid` in the next cycle with `data_out=4'b1010` and `toggle_count=2`.
- **Gaps:** same `q_in` sequence with `q_valid=0` cycles interleaved. Expect an identical word, with `data_valid` one cycle after the 4th valid sample.
- **Back-pressure and overflow:** hold `data_ready=0` and complete two words, first 4'b0001 then 4'b1111. Expect `data_out=4'b0001` held and `overflow=1` after the second completion. Then raise `data_ready` and expect one handshake, then EMPTY.
- **Simultaneous events:** FULL with `data_ready=1` on the same cycle as a completion. Expect the new word to appear on the next cycle, `data_valid` to stay 1 and `overflow` to stay 0.
- **Saturation:** CW=3. Drive 10 toggles (`q_in` alternating). Expect `toggle_count=7` holding.
- **Reset mid-word:** W=4. After 2 valid bits with `q_in` ending at 1, assert `rst` for 1 cycle. Expect all outputs 0 and `q_ref=0`. The next `q_in=1` must decode as `t=1`.
